// File: rtl/spi_slave_intf_if.sv
// SPI pin and host-word bundle between the board-level SPI pins / host logic and the slave front-end.
interface spi_slave_intf_if #(
   parameter int unsigned DATA_WIDTH = 12
);
   logic                  i_ss;
   logic                  i_sclk;
   logic                  i_mosi;
   logic                  o_miso;
   logic [DATA_WIDTH-1:0] i_data;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_data_ready;

   modport slave (
      input  i_ss,
      input  i_sclk,
      input  i_mosi,
      input  i_data,
      output o_miso,
      output o_data,
      output o_data_ready
   );

   modport master (
      output i_ss,
      output i_sclk,
      output i_mosi,
      output i_data,
      input  o_miso,
      input  o_data,
      input  o_data_ready
   );
endinterface

// File: rtl/spi_slave_intf.sv
// SPI mode-3 slave front-end: oversamples the asynchronous SPI pins on the system clock,
// assembles fixed-length frames and returns a host-supplied word on MISO in the same frame.
module spi_slave_intf #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned FRAME_BITS = 16
) (
   input  logic            i_sys_clk,
   input  logic            i_sys_rst,
   spi_slave_intf_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   // Two-stage synchronisers, index 1 is the synchronised value
   logic [1:0]            ss_sync;
   logic [1:0]            sclk_sync;
   logic [1:0]            mosi_sync;
   logic                  sclk_d;
   logic                  csn_d;
   logic [1:0]            sync_vld;
   logic                  armed;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic [DATA_WIDTH-1:0] s_data;
   logic [DATA_WIDTH-1:0] s_data_nxt;
   logic [FRAME_BITS-1:0] m_data;
   logic [FRAME_BITS-1:0] m_data_nxt;
   logic                  rx_ready;
   logic                  rx_ready_nxt;
   logic                  rx_ready_d;
   logic                  tx_ready;
   logic                  tx_ready_nxt;

   logic [DATA_WIDTH-1:0] data_q;
   logic                  data_ready_q;
   logic                  miso_q;

   logic                  csn;
   logic                  mosi_s;
   logic                  sclk_rise;
   logic                  csn_fall;

   assign csn       = ss_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sclk_rise = sclk_sync[1] & ~sclk_d;
   // A frame may only start once a genuine (post-reset) high level on SS has been observed
   assign csn_fall  = csn_d & ~csn & armed;

   assign bus.o_miso       = miso_q;
   assign bus.o_data       = data_q;
   assign bus.o_data_ready = data_ready_q;

   // Synchronisers, edge-detect history and frame-start arming
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         ss_sync   <= 2'b11;
         sclk_sync <= 2'b11;
         mosi_sync <= 2'b00;
         csn_d     <= 1'b1;
         sclk_d    <= 1'b1;
         sync_vld  <= 2'b00;
         armed     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[0], bus.i_ss};
         sclk_sync <= {sclk_sync[0], bus.i_sclk};
         mosi_sync <= {mosi_sync[0], bus.i_mosi};
         csn_d     <= csn;
         sclk_d    <= sclk_sync[1];
         sync_vld  <= {sync_vld[0], 1'b1};
         armed     <= armed | (sync_vld[1] & csn);
      end
   end

   // Frame state and shift registers
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         s_data     <= '0;
         m_data     <= '0;
         rx_ready   <= 1'b0;
         rx_ready_d <= 1'b0;
         tx_ready   <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         s_data     <= s_data_nxt;
         m_data     <= m_data_nxt;
         rx_ready   <= rx_ready_nxt;
         rx_ready_d <= rx_ready;
         tx_ready   <= tx_ready_nxt;
      end
   end

   // Next-state logic: shift on SCLK rises, stop after FRAME_BITS, abort on SS rising early
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      s_data_nxt   = s_data;
      m_data_nxt   = m_data;
      rx_ready_nxt = 1'b0;
      tx_ready_nxt = tx_ready;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_IDLE;
         end
         ST_SHIFT: begin
            if (csn) begin
               state_nxt    = ST_IDLE;
               tx_ready_nxt = 1'b0;
            end else if (sclk_rise) begin
               s_data_nxt = (s_data << 1) | DATA_WIDTH'(mosi_s);
               m_data_nxt = m_data << 1;
               count_nxt  = count + CNT_W'(1);
               if (count == CNT_W'(FRAME_BITS - 1)) begin
                  rx_ready_nxt = 1'b1;
                  tx_ready_nxt = 1'b0;
                  state_nxt    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (csn) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (csn_fall) begin
         state_nxt    = ST_SHIFT;
         count_nxt    = '0;
         s_data_nxt   = '0;
         m_data_nxt   = FRAME_BITS'(bus.i_data);
         tx_ready_nxt = 1'b1;
      end
   end

   // Registered outputs: word hand-off one cycle after rx_ready_d, MISO forced low outside a frame
   always_ff @(posedge i_sys_clk) begin
      if (!i_sys_rst) begin
         data_q       <= '0;
         data_ready_q <= 1'b0;
         miso_q       <= 1'b0;
      end else begin
         data_ready_q <= rx_ready_d;
         if (rx_ready_d) begin
            data_q <= s_data;
         end
         miso_q <= ~csn & tx_ready & m_data[FRAME_BITS-1];
      end
   end
endmodule

// File: tb/tb_spi_slave_intf.sv
// Directed bench for spi_slave_intf: table of SPI frames with loopback of the received word,
// plus hand-written abort and mid-frame reset sequences.
module tb_spi_slave_intf;
   localparam int unsigned DW = 12;
   localparam int unsigned FB = 16;
   localparam int unsigned NV = 7;

   typedef struct {
      logic [15:0] mosi;
      int          nbits;
      int          exp_strobes;
      logic [11:0] exp_data;
      logic [15:0] exp_miso;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_slave_intf_if #(.DATA_WIDTH(DW)) bus ();

   spi_slave_intf #(.DATA_WIDTH(DW), .FRAME_BITS(FB)) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst_n),
      .bus       (bus)
   );

   int            total = 0;
   int            bad   = 0;
   int            strobes   = 0;
   int            width_err = 0;
   logic          prev_rdy  = 1'b0;
   logic [DW-1:0] strobe_data = '0;
   logic [DW-1:0] loop_data   = '0;

   assign bus.i_data = loop_data;

   // Strobe monitor with loopback of the received word into the next transmit word
   always @(negedge clk) begin
      if (bus.o_data_ready === 1'b1) begin
         strobes     = strobes + 1;
         strobe_data = bus.o_data;
         loop_data   = bus.o_data;
         if (prev_rdy) width_err = width_err + 1;
      end
      prev_rdy = (bus.o_data_ready === 1'b1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Master side of one frame: mode 3, half-period 25 ns; returns MISO bits and strobe latency
   task automatic do_frame(input logic [15:0] v, input int n, output logic [15:0] rx, output int lat);
      rx  = '0;
      lat = 0;
      bus.i_ss = 1'b0;
      #60;
      for (int i = 0; i < n; i++) begin
         bus.i_sclk = 1'b0;
         bus.i_mosi = v[15-i];
         #25;
         rx = {rx[14:0], bus.o_miso};
         bus.i_sclk = 1'b1;
         if (i != n - 1) #25;
      end
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.o_data_ready === 1'b1) lat = c;
      end
      @(negedge clk);
      #2;
      bus.i_ss = 1'b1;
      #60;
   endtask

   vec_t        vecs [NV];
   logic [15:0] rx;
   int          lat;
   int          s0;

   initial begin
      vecs[0] = '{16'h0001, 16, 1, 12'h001, 16'h0000};
      vecs[1] = '{16'h0003, 16, 1, 12'h003, 16'h0001};
      vecs[2] = '{16'h0008, 16, 1, 12'h008, 16'h0003};
      vecs[3] = '{16'h0002, 16, 1, 12'h002, 16'h0008};
      vecs[4] = '{16'hFABC, 16, 1, 12'hABC, 16'h0002};
      vecs[5] = '{16'h1234,  9, 0, 12'hABC, 16'h0015};
      vecs[6] = '{16'h0055, 16, 1, 12'h055, 16'h0ABC};

      bus.i_ss   = 1'b1;
      bus.i_sclk = 1'b1;
      bus.i_mosi = 1'b0;
      rst_n      = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("reset_o_data", 32'(bus.o_data), 32'h0);
      check("reset_ready", 32'(bus.o_data_ready), 32'h0);
      check("reset_miso", 32'(bus.o_miso), 32'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #60;

      for (int k = 0; k < int'(NV); k++) begin
         s0 = strobes;
         do_frame(vecs[k].mosi, vecs[k].nbits, rx, lat);
         check($sformatf("v%0d_strobes", k), 32'(strobes - s0), 32'(vecs[k].exp_strobes));
         check($sformatf("v%0d_o_data", k), 32'(bus.o_data), 32'(vecs[k].exp_data));
         check($sformatf("v%0d_miso", k), 32'(rx), 32'(vecs[k].exp_miso));
         if (vecs[k].exp_strobes != 0) begin
            check($sformatf("v%0d_strobe_data", k), 32'(strobe_data), 32'(vecs[k].exp_data));
            check($sformatf("v%0d_latency", k), 32'(lat), 32'd5);
         end
      end

      // Reset in the middle of a frame, SS still low afterwards: no frame may start
      s0 = strobes;
      bus.i_ss = 1'b0;
      #60;
      for (int i = 0; i < 5; i++) begin
         bus.i_sclk = 1'b0; bus.i_mosi = 1'b1; #25;
         bus.i_sclk = 1'b1; #25;
      end
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #2;
      check("midrst_o_data", 32'(bus.o_data), 32'h0);
      check("midrst_miso", 32'(bus.o_miso), 32'h0);
      rst_n = 1'b1;
      #60;
      for (int i = 0; i < 16; i++) begin
         bus.i_sclk = 1'b0; bus.i_mosi = i[0]; #25;
         bus.i_sclk = 1'b1; #25;
      end
      #100;
      check("midrst_no_strobe", 32'(strobes - s0), 32'd0);
      bus.i_ss = 1'b1;
      #60;
      do_frame(16'h0123, 16, rx, lat);
      check("post_rst_strobes", 32'(strobes - s0), 32'd1);
      check("post_rst_o_data", 32'(bus.o_data), 32'h123);
      check("post_rst_strobe_data", 32'(strobe_data), 32'h123);
      check("post_rst_miso", 32'(rx), 32'h0055);
      check("post_rst_latency", 32'(lat), 32'd5);
      check("strobe_width", 32'(width_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
